// File: rtl/i2c_pkg.sv
// i2c_pkg: FSM state encoding and line filter constants shared by the I2C slaves
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, ADDRESS, ACK, WRITE_1, WRITE_2, READ_1, READ_2, READ_3} i2c_state_e;
  localparam logic LINE_IDLE = 1'b1;
  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
  } line_t;
endpackage

// File: rtl/i2c_reg_bank_if.sv
// i2c_reg_bank_if: I2C pin pairs split into input, drive value and tri-state enable
interface i2c_reg_bank_if;
  logic scl_i, scl_o, scl_t, sda_i, sda_o, sda_t;
  modport slave (input scl_i, sda_i, output scl_o, scl_t, sda_o, sda_t);
  modport master (output scl_i, sda_i, input scl_o, scl_t, sda_o, sda_t);
endinterface

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: majority-free glitch filter and edge detector for one I2C line
module i2c_line_filter import i2c_pkg::*; #(
  parameter int FILTER_LEN = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  d,
  output line_t q
);
  logic [FILTER_LEN-1:0] sh;
  // level only moves once the whole window agrees; edges compare against the held level
  always_ff @(posedge clk)
    if (rst) begin
      sh <= {FILTER_LEN{LINE_IDLE}};
      q <= {LINE_IDLE, 2'b00};
    end else begin
      sh <= {sh[FILTER_LEN-2:0], d};
      q.lvl <= &sh ? 1'b1 : ~|sh ? 1'b0 : q.lvl;
      q.rise <= &sh & ~q.lvl;
      q.fall <= ~|sh & q.lvl;
    end
endmodule

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: I2C slave fronting NUM_REGS 8-bit registers with pointer and auto-increment
module i2c_reg_bank import i2c_pkg::*; #(
  parameter int         FILTER_LEN = 4,
  parameter logic [6:0] DEV_ADDR   = 7'h70,
  parameter int         NUM_REGS   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  i2c_reg_bank_if.slave           bus,
  input  logic [NUM_REGS-1:0]     local_wr,
  input  logic [NUM_REGS*8-1:0]   local_data,
  output logic [NUM_REGS*8-1:0]   reg_data,
  output logic [NUM_REGS-1:0]     i2c_wr_strobe,
  output logic                    busy
);
  localparam int PTR_W = $clog2(NUM_REGS);
  line_t scl, sda;
  i2c_state_e state, state_d;
  logic [7:0] shreg, rx;
  logic [7:0] regs [NUM_REGS];
  logic [2:0] bit_cnt;
  logic [PTR_W-1:0] ptr, ptr_inc;
  logic rw, first_byte, sda_q, sda_d, busy_d;
  logic st, sp, sr, sf, byte_done, addr_ok, ptr_ok, wr_hit;
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (.clk(clk), .rst(rst), .d(bus.scl_i), .q(scl));
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (.clk(clk), .rst(rst), .d(bus.sda_i), .q(sda));
  assign st = sda.fall & scl.lvl;
  assign sp = sda.rise & scl.lvl;
  assign sr = scl.rise;
  assign sf = scl.fall;
  assign rx = {shreg[6:0], sda.lvl};
  assign byte_done = sr & (bit_cnt == 3'd7);
  assign addr_ok = rx[7:1] == DEV_ADDR;
  assign ptr_ok = {1'b0, rx} < 9'(NUM_REGS);
  // first_byte is set once the pointer byte of the current write has been taken
  assign wr_hit = state == WRITE_2 && byte_done && first_byte;
  assign ptr_inc = ptr == PTR_W'(NUM_REGS - 1) ? '0 : ptr + 1'b1;
  assign bus.scl_o = 1'b1;
  assign bus.scl_t = 1'b1;
  assign bus.sda_o = sda_q;
  assign bus.sda_t = sda_q;
  always_ff @(posedge clk) state <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state;
    case (state)
      ADDRESS: if (byte_done) state_d = addr_ok ? ACK : IDLE;
      ACK:     if (sf) state_d = rw ? READ_1 : WRITE_1;
      WRITE_1: if (sf) state_d = WRITE_2;
      WRITE_2: if (byte_done) state_d = first_byte || ptr_ok ? ACK : IDLE;
      READ_1:  if (sf && bit_cnt == 3'd7) state_d = READ_2;
      READ_2:  if (sf) state_d = READ_3;
      READ_3:  if (sr) state_d = sda.lvl ? IDLE : READ_1;
      default: ;
    endcase
    if (st) state_d = ADDRESS;
    if (sp) state_d = IDLE;
  end
  always_comb begin
    sda_d = (st || sp) ? 1'b1 :
            !sf ? sda_q :
            state == ACK ? 1'b0 :
            state == READ_1 ? shreg[7] :
            (state == WRITE_1 || state == READ_2) ? 1'b1 : sda_q;
    busy_d = state_d != IDLE && (busy || state_d == ACK);
  end
  always_ff @(posedge clk)
    if (rst) begin
      sda_q <= 1'b1;
      busy <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      ptr <= '0;
      rw <= 1'b0;
      first_byte <= 1'b0;
      i2c_wr_strobe <= '0;
    end else begin
      sda_q <= sda_d;
      busy <= busy_d;
      i2c_wr_strobe <= wr_hit ? NUM_REGS'(1) << ptr : '0;
      if (st) begin
        bit_cnt <= '0;
        first_byte <= 1'b0;
      end else if (!sp) case (state)
        ADDRESS: if (sr) begin
          shreg <= rx;
          bit_cnt <= bit_cnt + 1'b1;
          rw <= rx[0];
        end
        WRITE_2: if (sr) begin
          shreg <= rx;
          bit_cnt <= bit_cnt + 1'b1;
          if (byte_done && first_byte) ptr <= ptr_inc;
          else if (byte_done && ptr_ok) begin
            ptr <= rx[PTR_W-1:0];
            first_byte <= 1'b1;
          end
        end
        ACK: if (sf && rw) begin
          shreg <= regs[ptr];
          ptr <= ptr_inc;
        end
        READ_1: if (sf) begin
          shreg <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
        end
        READ_3: if (sr && !sda.lvl) begin
          shreg <= regs[ptr];
          ptr <= ptr_inc;
        end
        default: ;
      endcase
    end
  // a local load in the same cycle as an I2C write to the same entry takes precedence
  always_ff @(posedge clk)
    for (int k = 0; k < NUM_REGS; k++)
      regs[k] <= rst ? 8'h00 : local_wr[k] ? local_data[8*k +: 8] : wr_hit && ptr == PTR_W'(k) ? rx : regs[k];
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_data[8*i +: 8] = regs[i];
  end
endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: bit-banged I2C master with scoreboarded bus responses and write strobes
module tb_i2c_reg_bank;
  localparam int Q = 12;
  logic clk, rst, m_scl, m_sda, sda_bus;
  logic [3:0] local_wr, i2c_wr_strobe;
  logic [31:0] local_data, reg_data;
  logic busy;
  logic [7:0] rd_addr = 8'hE1;
  int errors = 0, checks = 0;
  int exp_q[$], obs_q[$];
  string nm_q[$];
  logic [3:0] sq[$];
  logic [31:0] rq[$];
  int o_v;
  string o_n;

  i2c_reg_bank_if bus();
  assign sda_bus = m_sda & bus.sda_o;
  assign bus.scl_i = m_scl;
  assign bus.sda_i = sda_bus;

  i2c_reg_bank #(.FILTER_LEN(4), .DEV_ADDR(7'h70), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .local_wr(local_wr), .local_data(local_data),
    .reg_data(reg_data), .i2c_wr_strobe(i2c_wr_strobe), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_bus(input string n, input int e);
    nm_q.push_back(n);
    exp_q.push_back(e);
  endtask

  task automatic expect_wr(input logic [3:0] s, input logic [31:0] r);
    sq.push_back(s);
    rq.push_back(r);
  endtask

  task automatic start_c;
    m_sda = 1'b1; w(Q); m_scl = 1'b1; w(Q); m_sda = 1'b0; w(Q); m_scl = 1'b0; w(Q);
  endtask

  task automatic stop_c;
    m_sda = 1'b0; w(Q); m_scl = 1'b1; w(Q); m_sda = 1'b1; w(Q);
  endtask

  // co pulses local_wr[2] in the cycle the DUT acts on this SCL rise (filter latency 5)
  task automatic wbit(input logic b, input bit gl, input bit co);
    m_sda = b;
    if (gl) begin
      w(4); m_scl = 1'b1; w(2); m_scl = 1'b0; w(Q - 6);
    end else w(Q);
    m_scl = 1'b1;
    if (co) begin
      w(5); local_wr = 4'b0100; w(1); local_wr = 4'b0000; w(2 * Q - 6);
    end else w(2 * Q);
    m_scl = 1'b0; w(Q);
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; w(Q); m_scl = 1'b1; w(Q); b = sda_bus; w(Q); m_scl = 1'b0; w(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, input logic ea, input bit gl, input bit co, input string n);
    logic a;
    expect_bus(n, ea);
    for (int i = 7; i >= 0; i--) wbit(d[i], gl, co && i == 0);
    rbit(a);
    obs_q.push_back(a);
  endtask

  task automatic rbyte(input logic [7:0] e, input logic ack, input string n);
    logic [7:0] v;
    logic b;
    v = '0;
    expect_bus(n, e);
    for (int i = 0; i < 8; i++) begin
      rbit(b);
      v = {v[6:0], b};
    end
    obs_q.push_back(v);
    wbit(ack, 1'b0, 1'b0);
  endtask

  always @(negedge clk)
    if (obs_q.size() != 0) begin
      o_v = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", o_v);
      end else begin
        o_n = nm_q.pop_front();
        chk(o_n, o_v, exp_q.pop_front());
      end
    end

  always @(negedge clk)
    if (!rst && i2c_wr_strobe != 4'b0000) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected: got %0h expected none", i2c_wr_strobe);
      end else begin
        chk("wr_strobe", i2c_wr_strobe, sq.pop_front());
        chk("reg_data_at_strobe", reg_data, rq.pop_front());
      end
    end

  initial begin
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; local_wr = '0; local_data = '0;
    w(4); rst = 1'b0; w(2);
    chk("rst_reg_data", reg_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda_o", bus.sda_o, 1'b1);
    chk("rst_sda_t", bus.sda_t, 1'b1);
    chk("rst_scl_o_t", {bus.scl_o, bus.scl_t}, 2'b11);
    chk("rst_strobe", i2c_wr_strobe, 4'b0);
    // pointer 1, two data bytes
    start_c;
    wbyte(8'hE0, 1'b0, 0, 0, "t1_addr_ack");
    chk("t1_busy", busy, 1'b1);
    wbyte(8'h01, 1'b0, 0, 0, "t1_ptr_ack");
    expect_wr(4'b0010, 32'h0000A500);
    wbyte(8'hA5, 1'b0, 0, 0, "t1_d0_ack");
    expect_wr(4'b0100, 32'h003CA500);
    wbyte(8'h3C, 1'b0, 0, 0, "t1_d1_ack");
    stop_c;
    chk("t1_busy_stop", busy, 1'b0);
    chk("t1_regs", reg_data, 32'h003CA500);
    // write across the pointer wrap
    start_c;
    wbyte(8'hE0, 1'b0, 0, 0, "w_addr_ack");
    wbyte(8'h03, 1'b0, 0, 0, "w_ptr_ack");
    expect_wr(4'b1000, 32'h773CA500);
    wbyte(8'h77, 1'b0, 0, 0, "w_d0_ack");
    expect_wr(4'b0001, 32'h773CA55A);
    wbyte(8'h5A, 1'b0, 0, 0, "w_d1_ack");
    stop_c;
    // pointer 3, repeated start, read with wrap
    start_c;
    wbyte(8'hE0, 1'b0, 0, 0, "t2_addr_ack");
    wbyte(8'h03, 1'b0, 0, 0, "t2_ptr_ack");
    start_c;
    wbyte(8'hE1, 1'b0, 0, 0, "t2_raddr_ack");
    rbyte(8'h77, 1'b0, "t2_rd_reg3");
    rbyte(8'h5A, 1'b0, "t2_rd_reg0");
    rbyte(8'hA5, 1'b1, "t2_rd_reg1");
    chk("t2_sda_released", bus.sda_o, 1'b1);
    chk("t2_busy_nack", busy, 1'b0);
    stop_c;
    // wrong address
    start_c;
    wbyte(8'hE2, 1'b1, 0, 0, "t3_addr_nack");
    chk("t3_busy", busy, 1'b0);
    wbyte(8'h00, 1'b1, 0, 0, "t3_ignored");
    stop_c;
    chk("t3_regs", reg_data, 32'h773CA55A);
    // out-of-range pointer, then read from the retained pointer (2)
    start_c;
    wbyte(8'hE0, 1'b0, 0, 0, "t4_addr_ack");
    wbyte(8'h04, 1'b1, 0, 0, "t4_ptr_nack");
    chk("t4_busy", busy, 1'b0);
    wbyte(8'h99, 1'b1, 0, 0, "t4_ignored");
    stop_c;
    start_c;
    wbyte(8'hE1, 1'b0, 0, 0, "t4_raddr_ack");
    rbyte(8'h3C, 1'b1, "t4_ptr_kept");
    stop_c;
    chk("t4_regs", reg_data, 32'h773CA55A);
    // local write collides with I2C write to reg2
    local_data = 32'h0011_0000;
    start_c;
    wbyte(8'hE0, 1'b0, 0, 0, "t5_addr_ack");
    wbyte(8'h02, 1'b0, 0, 0, "t5_ptr_ack");
    expect_wr(4'b0100, 32'h7711A55A);
    wbyte(8'h22, 1'b0, 0, 1, "t5_d_ack");
    stop_c;
    chk("t5_regs", reg_data, 32'h7711A55A);
    // 2-cycle SCL glitches inside every low phase
    start_c;
    wbyte(8'hE0, 1'b0, 0, 0, "t6_addr_ack");
    wbyte(8'h01, 1'b0, 0, 0, "t6_ptr_ack");
    expect_wr(4'b0010, 32'h7711C35A);
    wbyte(8'hC3, 1'b0, 1, 0, "t6_glitch_ack");
    stop_c;
    // reset while the slave holds SDA low for the address ACK
    start_c;
    expect_bus("t7_addr_ack", 0);
    for (int i = 7; i >= 0; i--) wbit(rd_addr[i], 1'b0, 1'b0);
    m_sda = 1'b1; w(Q); m_scl = 1'b1; w(Q);
    obs_q.push_back(sda_bus);
    chk("t7_sda_driven", bus.sda_o, 1'b0);
    rst = 1'b1; w(1); rst = 1'b0;
    chk("t7_sda_released", bus.sda_o, 1'b1);
    chk("t7_regs_cleared", reg_data, 32'h0);
    chk("t7_busy", busy, 1'b0);
    w(Q - 1); m_scl = 1'b0; w(Q);
    rbyte(8'hFF, 1'b1, "t7_bus_ignored");
    stop_c;
    start_c;
    wbyte(8'hE0, 1'b0, 0, 0, "t8_addr_ack");
    wbyte(8'h03, 1'b0, 0, 0, "t8_ptr_ack");
    expect_wr(4'b1000, 32'h42000000);
    wbyte(8'h42, 1'b0, 0, 0, "t8_d0_ack");
    expect_wr(4'b0001, 32'h42000043);
    wbyte(8'h43, 1'b0, 0, 0, "t8_d1_ack");
    start_c;
    wbyte(8'hE0, 1'b0, 0, 0, "t8_addr2_ack");
    wbyte(8'h03, 1'b0, 0, 0, "t8_ptr2_ack");
    start_c;
    wbyte(8'hE1, 1'b0, 0, 0, "t8_raddr_ack");
    rbyte(8'h42, 1'b0, "t8_rd_reg3");
    rbyte(8'h43, 1'b1, "t8_rd_reg0");
    stop_c;
    w(20);
    chk("sb_bus_left", exp_q.size(), 0);
    chk("sb_strobe_left", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
